// File: rtl/spectro_bank_writer.sv
// Spectrogram bank writer: stores the samples of one acoustic emission into a
// ping-pong memory addressed {bank, idx}. Emits bank-full and end-of-event
// pulses for the readout controller and flags overruns of unacknowledged banks.
module spectro_bank_writer #(
    parameter int unsigned DATA_W  = 16,
    parameter int unsigned IDX_W   = 8,
    parameter int unsigned DEPTH   = 200,
    parameter int unsigned HOLDOFF = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ae_active,
    input  logic              sample_valid,
    input  logic [DATA_W-1:0] sample_data,
    input  logic [1:0]        bank_ack,
    output logic              mem_we,
    output logic [IDX_W:0]    mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              bank0_full,
    output logic              bank1_full,
    output logic              memorization_completed,
    output logic [IDX_W-1:0]  idx_final,
    output logic              bank,
    output logic              overrun
);

    localparam int unsigned    CNT_W    = $clog2(HOLDOFF + 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] CNT_END  = CNT_W'(HOLDOFF - 1);

    typedef enum logic [1:0] {StIdle, StAcq, StHoldoff} state_t;

    state_t           state_q;
    logic [IDX_W-1:0] idx_q;
    logic [1:0]       pending_q;
    logic             wrote_q;   // at least one sample written in this event
    logic [CNT_W-1:0] cnt_q;

    logic             accept;
    logic             fill;
    logic             end_evt;
    logic [IDX_W-1:0] idx_next;
    logic             wrote_next;

    // A sample taken in the same cycle as the event end is counted first.
    assign accept     = (state_q == StAcq) && sample_valid;
    assign fill       = accept && (idx_q == LAST_IDX);
    assign end_evt    = (state_q == StAcq) && !ae_active;
    assign idx_next   = fill ? '0 : (accept ? idx_q + 1'b1 : idx_q);
    assign wrote_next = wrote_q | accept;

    // Control FSM with registered memory-write and pulse outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q                <= StIdle;
            idx_q                  <= '0;
            pending_q              <= '0;
            wrote_q                <= 1'b0;
            cnt_q                  <= '0;
            mem_we                 <= 1'b0;
            mem_addr               <= '0;
            mem_wdata              <= '0;
            bank0_full             <= 1'b0;
            bank1_full             <= 1'b0;
            memorization_completed <= 1'b0;
            idx_final              <= '0;
            bank                   <= 1'b0;
            overrun                <= 1'b0;
        end else begin
            mem_we                 <= 1'b0;
            bank0_full             <= 1'b0;
            bank1_full             <= 1'b0;
            memorization_completed <= 1'b0;
            // Acks clear first; a same-cycle set below overrides the clear.
            pending_q              <= pending_q & ~bank_ack;

            unique case (state_q)
                StIdle: begin
                    if (ae_active) begin
                        state_q <= StAcq;
                        wrote_q <= 1'b0;
                    end
                end

                StAcq: begin
                    if (accept) begin
                        mem_we    <= 1'b1;
                        mem_addr  <= {bank, idx_q};
                        mem_wdata <= sample_data;
                    end
                    if (fill) begin
                        if (bank) bank1_full <= 1'b1;
                        else      bank0_full <= 1'b1;
                        if (pending_q[bank]) overrun <= 1'b1;
                        pending_q[bank] <= 1'b1;
                        bank            <= ~bank;
                    end
                    idx_q   <= idx_next;
                    wrote_q <= wrote_next;

                    if (end_evt) begin
                        if (idx_next != '0) begin
                            // Partially filled bank: hand it over to readout.
                            memorization_completed <= 1'b1;
                            idx_final              <= idx_next - 1'b1;
                            if (pending_q[bank]) overrun <= 1'b1;
                            pending_q[bank] <= 1'b1;
                            bank            <= ~bank;
                            idx_q           <= '0;
                            state_q         <= StHoldoff;
                            cnt_q           <= '0;
                        end else if (wrote_next) begin
                            // Last sample exactly filled a bank; already toggled.
                            state_q <= StHoldoff;
                            cnt_q   <= '0;
                        end else begin
                            state_q <= StIdle;
                        end
                    end
                end

                StHoldoff: begin
                    if (cnt_q == CNT_END) state_q <= StIdle;
                    else                  cnt_q   <= cnt_q + 1'b1;
                end

                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_spectro_bank_writer.sv
// Directed testbench for spectro_bank_writer: table of whole events with
// hand-computed results, plus hand sequences for holdoff and async reset.
module tb_spectro_bank_writer;

    localparam int unsigned DATA_W  = 16;
    localparam int unsigned IDX_W   = 8;
    localparam int unsigned DEPTH   = 200;
    localparam int unsigned HOLDOFF = 16;

    logic              clk;
    logic              reset;
    logic              ae_active;
    logic              sample_valid;
    logic [DATA_W-1:0] sample_data;
    logic [1:0]        bank_ack;
    logic              mem_we;
    logic [IDX_W:0]    mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              bank0_full;
    logic              bank1_full;
    logic              memorization_completed;
    logic [IDX_W-1:0]  idx_final;
    logic              bank;
    logic              overrun;

    spectro_bank_writer #(
        .DATA_W (DATA_W),
        .IDX_W  (IDX_W),
        .DEPTH  (DEPTH),
        .HOLDOFF(HOLDOFF)
    ) dut (
        .clk                   (clk),
        .reset                 (reset),
        .ae_active             (ae_active),
        .sample_valid          (sample_valid),
        .sample_data           (sample_data),
        .bank_ack              (bank_ack),
        .mem_we                (mem_we),
        .mem_addr              (mem_addr),
        .mem_wdata             (mem_wdata),
        .bank0_full            (bank0_full),
        .bank1_full            (bank1_full),
        .memorization_completed(memorization_completed),
        .idx_final             (idx_final),
        .bank                  (bank),
        .overrun               (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int pass_cnt = 0;
    int total_cnt = 0;

    // Monitor: record every write and pulse, sampled away from the active edge.
    logic [IDX_W:0]    wq_addr[$];
    logic [DATA_W-1:0] wq_data[$];
    int                f0_cnt = 0;
    int                f1_cnt = 0;
    int                comp_cnt = 0;
    logic [IDX_W+1:0]  f0_at = '0;
    logic [IDX_W+1:0]  f1_at = '0;

    always @(negedge clk) begin
        if (mem_we) begin
            wq_addr.push_back(mem_addr);
            wq_data.push_back(mem_wdata);
        end
        if (bank0_full) begin
            f0_cnt++;
            f0_at = {mem_we, mem_addr};
        end
        if (bank1_full) begin
            f1_cnt++;
            f1_at = {mem_we, mem_addr};
        end
        if (memorization_completed) comp_cnt++;
    end

    typedef struct {
        int n;          // samples in the event
        bit same_end;   // last sample arrives with ae_active already low
        bit auto_ack;   // readout acks each full bank right away
        bit ack_after;  // readout acks both banks after the event
        bit sb;         // bank the event starts in
        int f0;
        int f1;
        int comp;
        int idxf;
        bit exp_bank;
        bit exp_ovr;
    } vec_t;

    vec_t tbl[9];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset        = 1'b1;
        ae_active    = 1'b0;
        sample_valid = 1'b0;
        sample_data  = '0;
        bank_ack     = '0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic run_event(input vec_t v, input int ev);
        int q0, f0s, f1s, cs, errs, b;
        logic [IDX_W:0]    ea;
        logic [DATA_W-1:0] ed;
        q0  = wq_addr.size();
        f0s = f0_cnt;
        f1s = f1_cnt;
        cs  = comp_cnt;
        @(negedge clk);
        bank_ack     = '0;
        ae_active    = 1'b1;
        sample_valid = 1'b0;
        for (int k = 0; k < v.n; k++) begin
            @(negedge clk);
            bank_ack     = v.auto_ack ? {bank1_full, bank0_full} : 2'b00;
            ae_active    = !(v.same_end && k == v.n - 1);
            sample_valid = 1'b1;
            sample_data  = DATA_W'(ev * 1024 + k);
        end
        if (!(v.same_end && v.n > 0)) begin
            @(negedge clk);
            bank_ack     = v.auto_ack ? {bank1_full, bank0_full} : 2'b00;
            ae_active    = 1'b0;
            sample_valid = 1'b0;
        end
        @(negedge clk);
        bank_ack     = v.auto_ack ? {bank1_full, bank0_full} : 2'b00;
        ae_active    = 1'b0;
        sample_valid = 1'b0;
        repeat (3) @(negedge clk);
        bank_ack = '0;
        if (v.ack_after) begin
            bank_ack = 2'b11;
            @(negedge clk);
            bank_ack = '0;
        end
        repeat (HOLDOFF + 4) @(negedge clk);

        errs = 0;
        if (wq_addr.size() != q0 + v.n) errs++;
        else begin
            for (int k = 0; k < v.n; k++) begin
                b  = int'(v.sb) ^ ((k / DEPTH) % 2);
                ea = {b[0], IDX_W'(k % DEPTH)};
                ed = DATA_W'(ev * 1024 + k);
                if (wq_addr[q0 + k] !== ea || wq_data[q0 + k] !== ed) errs++;
            end
        end
        check($sformatf("ev%0d write_errors", ev), 64'(errs), 64'd0);
        check($sformatf("ev%0d bank0_full_cnt", ev), 64'(f0_cnt - f0s), 64'(v.f0));
        check($sformatf("ev%0d bank1_full_cnt", ev), 64'(f1_cnt - f1s), 64'(v.f1));
        check($sformatf("ev%0d completed_cnt", ev), 64'(comp_cnt - cs), 64'(v.comp));
        check($sformatf("ev%0d idx_final", ev), 64'(idx_final), 64'(v.idxf));
        check($sformatf("ev%0d bank", ev), 64'(bank), 64'(v.exp_bank));
        check($sformatf("ev%0d overrun", ev), 64'(overrun), 64'(v.exp_ovr));
        if (v.f0 != 0)
            check($sformatf("ev%0d bank0_full_with_write", ev), 64'(f0_at),
                  64'({1'b1, 1'b0, IDX_W'(DEPTH - 1)}));
        if (v.f1 != 0)
            check($sformatf("ev%0d bank1_full_with_write", ev), 64'(f1_at),
                  64'({1'b1, 1'b1, IDX_W'(DEPTH - 1)}));
    endtask

    function automatic logic [63:0] all_outputs();
        return 64'({mem_we, mem_addr, mem_wdata, bank0_full, bank1_full,
                    memorization_completed, idx_final, bank, overrun});
    endfunction

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        int j, seen, f0s, f1s, cs;
        vec_t v;

        reset        = 1'b1;
        ae_active    = 1'b0;
        sample_valid = 1'b0;
        sample_data  = '0;
        bank_ack     = '0;

        //               n  same auto ackA sb  f0 f1 comp idxf bank ovr
        tbl[0] = '{450, 1'b0, 1'b1, 1'b1, 1'b0, 1, 1, 1, 49, 1'b1, 1'b0};
        tbl[1] = '{ 50, 1'b0, 1'b0, 1'b1, 1'b1, 0, 0, 1, 49, 1'b0, 1'b0};
        tbl[2] = '{200, 1'b0, 1'b1, 1'b1, 1'b0, 1, 0, 0, 49, 1'b1, 1'b0};
        tbl[3] = '{ 37, 1'b1, 1'b0, 1'b1, 1'b1, 0, 0, 1, 36, 1'b0, 1'b0};
        tbl[4] = '{200, 1'b1, 1'b1, 1'b1, 1'b0, 1, 0, 0, 36, 1'b1, 1'b0};
        tbl[5] = '{  0, 1'b0, 1'b0, 1'b0, 1'b1, 0, 0, 0, 36, 1'b1, 1'b0};
        tbl[6] = '{ 10, 1'b0, 1'b0, 1'b0, 1'b1, 0, 0, 1,  9, 1'b0, 1'b0};
        tbl[7] = '{ 20, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 1, 19, 1'b1, 1'b0};
        tbl[8] = '{  5, 1'b0, 1'b0, 1'b0, 1'b1, 0, 0, 1,  4, 1'b0, 1'b1};

        repeat (2) @(negedge clk);
        check("reset_outputs", all_outputs(), 64'd0);
        reset = 1'b0;
        @(negedge clk);
        check("after_reset_outputs", all_outputs(), 64'd0);

        for (int i = 0; i < 9; i++) run_event(tbl[i], i);

        // Holdoff: ae_active re-asserted 5 cycles after the event end is ignored.
        do_reset();
        @(negedge clk);
        ae_active = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            sample_valid = 1'b1;
            sample_data  = DATA_W'(16'h0a00 + k);
        end
        @(negedge clk);
        ae_active    = 1'b0;
        sample_valid = 1'b0;
        j    = 0;
        seen = 0;
        while (seen == 0 && j < 60) begin
            @(negedge clk);
            j++;
            if (mem_we) seen = j;
            else if (j == 5) begin
                ae_active    = 1'b1;
                sample_valid = 1'b1;
                sample_data  = 16'habcd;
            end
        end
        check("holdoff_first_write_cycle", 64'(seen), 64'(HOLDOFF + 3));
        check("holdoff_first_write_addr", 64'(mem_addr), 64'h100);
        ae_active    = 1'b0;
        sample_valid = 1'b0;
        repeat (HOLDOFF + 6) @(negedge clk);

        // Async reset in the middle of an event at idx=120.
        do_reset();
        @(negedge clk);
        ae_active = 1'b1;
        for (int k = 0; k < 120; k++) begin
            @(negedge clk);
            sample_valid = 1'b1;
            sample_data  = DATA_W'(k);
        end
        @(negedge clk);
        check("pre_reset_write_active", 64'({mem_we, mem_addr}), 64'({1'b1, 1'b0, 8'd119}));
        f0s = f0_cnt;
        f1s = f1_cnt;
        cs  = comp_cnt;
        #2;
        reset = 1'b1;
        #1;
        check("async_reset_outputs", all_outputs(), 64'd0);
        @(negedge clk);
        ae_active    = 1'b0;
        sample_valid = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        repeat (HOLDOFF + 4) @(negedge clk);
        check("reset_no_pulses", 64'((f0_cnt - f0s) + (f1_cnt - f1s) + (comp_cnt - cs)), 64'd0);
        check("reset_quiet_outputs", all_outputs(), 64'd0);
        v = '{5, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 1, 4, 1'b1, 1'b0};
        run_event(v, 20);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/spectro_bank_writer.md
Name: spectro_bank_writer

Overview:
- Upstream acquisition stage of the spectrogram readout path. Writes incoming spectrogram samples for one acoustic emission (AE) into a dual-bank (ping-pong) memory.
- Each bank holds DEPTH words; the write address is {bank, idx}.
- Produces the bank-full pulses, the end-of-memorization pulse and the final-index word consumed by the readout controller.
- Flags an overrun when a bank is overwritten before readout has acknowledged it.

Parameters:
DATA_W, 16, width of a spectrogram sample word
IDX_W, 8, in-bank index width
DEPTH, 200, words per bank (DEPTH <= 2**IDX_W)
HOLDOFF, 16, minimum idle cycles after an event before a new event is accepted

Ports:
clk  in  1  clock
reset  in  1  async active-high reset
ae_active  in  1  AE detector envelope; high while an event is in progress
sample_valid  in  1  sample_data valid this cycle
sample_data  in  DATA_W  spectrogram sample
bank_ack  in  2  one-cycle pulse per bank, from readout: bank fully read
mem_we  out  1  memory write enable
mem_addr  out  IDX_W+1  write address {bank, idx}
mem_wdata  out  DATA_W  write data
bank0_full  out  1  one-cycle pulse: bank 0 filled
bank1_full  out  1  one-cycle pulse: bank 1 filled
memorization_completed  out  1  one-cycle pulse: event ended mid-bank
idx_final  out  IDX_W  index of last word written by the ended event; stable from the pulse until the next pulse
bank  out  1  current write bank
overrun  out  1  sticky: bank overwritten while unacknowledged

Behaviour:
Reset (async, clk domain: reset/clk):
- All outputs 0: bank=0, idx=0, pending[1:0]=0, state=IDLE.
States:
- IDLE: wait for ae_active=1, then go to ACQ. Samples are ignored while in IDLE.
- ACQ: each cycle with sample_valid=1, write the sample at {bank, idx}.
  - Registered write: mem_we/mem_addr/mem_wdata appear one cycle after the sample is accepted.
  - idx increments after each write.
- Bank fill: when the write at idx=DEPTH-1 occurs:
  - pulse bank<bank>_full in the same cycle as that mem_we;
  - set pending[bank];
  - toggle bank; idx returns to 0;
  - remain in ACQ while ae_active=1.
- Event end, ACQ with ae_active=0:
  - If idx>0: pulse memorization_completed and load idx_final=idx-1, both in the same cycle; set pending[bank]; toggle bank; idx=0; go to HOLDOFF.
  - If idx=0 because the last sample exactly filled a bank: no memorization_completed; go to HOLDOFF. The bank already toggled on the full.
  - If no sample was written during the event: no pulses, no toggle; return to IDLE.
- Same-cycle sample and event end: if sample_valid=1 and ae_active=0 in the same ACQ cycle, the sample is written first and is included in idx_final.
- HOLDOFF: count HOLDOFF cycles, then go to IDLE. ae_active is ignored during HOLDOFF.
- Overrun: on a bank fill or event end, if pending[bank] is already set (bank not yet acknowledged), set overrun. The data is still written. overrun is cleared only by reset.
- bank_ack[n]: clears pending[n].
- Simultaneous set and ack on the same bank: set wins.
- idx never exceeds DEPTH-1; wrap occurs only via the bank-fill path.
- Reset mid-event: abandon the event immediately; no pulses are emitted.

Test Plan:
- Short event: DEPTH=200; ae_active high for 50 valid samples (0..49) -> mem_addr 0x000..0x031 with matching data; one memorization_completed pulse; idx_final=49; bank becomes 1.
- Long event: 450 samples -> bank0_full pulse with the write to 0x0C7; bank1_full pulse with the write to 0x1C7; 50 samples written to 0x000..0x031; completion with idx_final=49; bank=1.
- Exact boundary: 200 samples, ae_active falls right after the last sample -> bank0_full only; no memorization_completed; bank=1; HOLDOFF entered.
- Overrun: two short events with no bank_ack, then a third event -> the third event writes bank 0 again with pending[0]=1, so overrun=1. Repeat with bank_ack pulsed after each event -> overrun stays 0.
- Holdoff and empty event: ae_active re-asserted 5 cycles after an event end -> ignored until 16 cycles have elapsed. A pulse of ae_active with no sample_valid -> no outputs change.
- Async reset asserted during ACQ at idx=120 -> all outputs 0 immediately; no full or completion pulse; next event starts at address 0x000.
